// File: rtl/cache_req_arbiter_if.sv
// Two-port request bundle plus cache-controller side of the cache request arbiter.
// Latency: n/a (signal grouping only).
// Backpressure: requesters hold reqN_valid with payload until reqN_ready.
//
// Ports (signals grouped here):
//   reqN_valid/type/addr/wdata   requester -> arbiter  (N = 0,1)
//   reqN_ready/done/rdata        arbiter -> requester
//   c_req_valid/type/addr/wdata  arbiter -> cache controller
//   c_done_cache/c_rdata         cache controller -> arbiter
//   busy/grant_id                arbiter status
// Modports: slave = arbiter side, master = requester/controller side.
interface cache_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_type;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_done;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_valid;
   logic              req1_type;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_done;
   logic [DATA_W-1:0] req1_rdata;

   logic              c_req_valid;
   logic              c_req_type;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_done_cache;
   logic [DATA_W-1:0] c_rdata;

   logic              busy;
   logic              grant_id;

   modport slave (
      input  req0_valid, req0_type, req0_addr, req0_wdata,
      input  req1_valid, req1_type, req1_addr, req1_wdata,
      input  c_done_cache, c_rdata,
      output req0_ready, req0_done, req0_rdata,
      output req1_ready, req1_done, req1_rdata,
      output c_req_valid, c_req_type, c_addr, c_wdata,
      output busy, grant_id
   );

   modport master (
      output req0_valid, req0_type, req0_addr, req0_wdata,
      output req1_valid, req1_type, req1_addr, req1_wdata,
      output c_done_cache, c_rdata,
      input  req0_ready, req0_done, req0_rdata,
      input  req1_ready, req1_done, req1_rdata,
      input  c_req_valid, c_req_type, c_addr, c_wdata,
      input  busy, grant_id
   );
endinterface

// File: rtl/cache_req_arbiter.sv
// Arbitrates two requesters onto a single-outstanding cache controller port.
// Latency: accept edge -> >=1 ISSUE cycle -> 1-cycle done pulse (min 3 cycles).
// Backpressure: one transaction at a time; new requests wait (ready low) until IDLE.
//
// Ports: clk, rst (async active-high), bus (cache_req_arbiter_if.slave).
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the port not granted last;
// when undefined, port 0 always wins a tie.
module cache_req_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   cache_req_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic              grant_id_q, grant_id_d;
   logic              c_req_valid_q, c_req_valid_d;
   logic              c_req_type_q, c_req_type_d;
   logic [ADDR_W-1:0] c_addr_q, c_addr_d;
   logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              ready0, ready1;
   logic              any_valid;
   logic              winner;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_grant_q, last_grant_d;
`endif

   assign any_valid = bus.req0_valid | bus.req1_valid;

   // Winner is only meaningful while any_valid; a lone requester always wins.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.req0_valid && bus.req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = ~bus.req0_valid;
      end
`else
      winner = ~bus.req0_valid;
`endif
   end

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      c_req_valid_d = c_req_valid_q;
      c_req_type_d  = c_req_type_q;
      c_addr_d      = c_addr_q;
      c_wdata_d     = c_wdata_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      ready0        = 1'b0;
      ready1        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d  = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               ready0        = ~winner;
               ready1        = winner;
               grant_id_d    = winner;
               c_req_valid_d = 1'b1;
               if (winner) begin
                  c_req_type_d = bus.req1_type;
                  c_addr_d     = bus.req1_addr;
                  c_wdata_d    = bus.req1_wdata;
               end else begin
                  c_req_type_d = bus.req0_type;
                  c_addr_d     = bus.req0_addr;
                  c_wdata_d    = bus.req0_wdata;
               end
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = winner;
`endif
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Read data is captured for writes too, so the port always
            // sees whatever the controller returned on its last done.
            if (bus.c_done_cache) begin
               c_req_valid_d = 1'b0;
               if (grant_id_q) begin
                  rdata1_d = bus.c_rdata;
               end else begin
                  rdata0_d = bus.c_rdata;
               end
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d       = ST_IDLE;
            c_req_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_id_q    <= 1'b0;
         c_req_valid_q <= 1'b0;
         c_req_type_q  <= 1'b0;
         c_addr_q      <= '0;
         c_wdata_q     <= '0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         c_req_valid_q <= c_req_valid_d;
         c_req_type_q  <= c_req_type_d;
         c_addr_q      <= c_addr_d;
         c_wdata_q     <= c_wdata_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.req0_done   = (state_q == ST_RESP) && !grant_id_q;
   assign bus.req1_done   = (state_q == ST_RESP) &&  grant_id_q;
   assign bus.req0_rdata  = rdata0_q;
   assign bus.req1_rdata  = rdata1_q;
   assign bus.c_req_valid = c_req_valid_q;
   assign bus.c_req_type  = c_req_type_q;
   assign bus.c_addr      = c_addr_q;
   assign bus.c_wdata     = c_wdata_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: directed vector table plus
// hand-written sequences for long miss, tie arbitration and reset mid-issue.
// Inputs driven on the falling edge; outputs compared 1 time unit later.
module tb_cache_req_arbiter;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   cache_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   cache_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v0, t0;
      logic [31:0] a0, w0;
      logic        v1, t1;
      logic [31:0] a1, w1;
      logic        cd;
      logic [31:0] crd;
      logic [1:0]  e_rdy, e_done;
      logic        e_cvld, e_busy, e_gid, e_ctype;
      logic [31:0] e_caddr, e_cwdata, e_rd0, e_rd1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic v0, input logic t0, input logic [31:0] a0, input logic [31:0] w0,
      input logic v1, input logic t1, input logic [31:0] a1, input logic [31:0] w1,
      input logic cd, input logic [31:0] crd,
      input logic [1:0] e_rdy, input logic [1:0] e_done, input logic e_cvld,
      input logic e_busy, input logic e_gid, input logic e_ctype,
      input logic [31:0] e_caddr, input logic [31:0] e_cwdata,
      input logic [31:0] e_rd0, input logic [31:0] e_rd1);
      vec_t v;
      v.v0 = v0; v.t0 = t0; v.a0 = a0; v.w0 = w0;
      v.v1 = v1; v.t1 = t1; v.a1 = a1; v.w1 = w1;
      v.cd = cd; v.crd = crd;
      v.e_rdy = e_rdy; v.e_done = e_done; v.e_cvld = e_cvld; v.e_busy = e_busy;
      v.e_gid = e_gid; v.e_ctype = e_ctype; v.e_caddr = e_caddr;
      v.e_cwdata = e_cwdata; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v0, input logic t0, input logic [31:0] a0,
                        input logic v1, input logic t1, input logic [31:0] a1,
                        input logic cd, input logic [31:0] crd);
      bus.req0_valid   = v0;
      bus.req0_type    = t0;
      bus.req0_addr    = a0;
      bus.req1_valid   = v1;
      bus.req1_type    = t1;
      bus.req1_addr    = a1;
      bus.c_done_cache = cd;
      bus.c_rdata      = crd;
   endtask

   function automatic logic [1:0] rdy();
      return {bus.req1_ready, bus.req0_ready};
   endfunction

   function automatic logic [1:0] dn();
      return {bus.req1_done, bus.req0_done};
   endfunction

   initial begin
      logic exp_g [3];
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.req0_wdata = '0;
      bus.req1_wdata = '0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cvld",  bus.c_req_valid, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_gid",   bus.grant_id, 0);
      chk("rst_done",  dn(), 0);
      chk("rst_ctype", bus.c_req_type, 0);
      chk("rst_caddr", bus.c_addr, 0);
      chk("rst_cwdat", bus.c_wdata, 0);
      chk("rst_rd0",   bus.req0_rdata, 0);
      chk("rst_rd1",   bus.req1_rdata, 0);
      @(negedge clk);
      rst = 1'b0;

      // ---- vector table: single read, single write, stray done ----
      //            v0 t0 a0        w0  v1 t1 a1       w1            cd crd            rdy  done cv bz g  ty caddr     cwdata        rd0           rd1
      vecs.push_back(mk(1,0,32'h100,0, 0,0,0,0,             0,0,            2'b01,2'b00,0,0,0,0, 0,        0,            0,            0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b00,1,1,0,0, 32'h100,  0,            0,            0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             1,32'hDEADBEEF, 2'b00,2'b00,1,1,0,0, 32'h100,  0,            0,            0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b01,0,1,0,0, 0,        0,            32'hDEADBEEF, 0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b00,0,0,0,0, 0,        0,            32'hDEADBEEF, 0));
      vecs.push_back(mk(0,0,0,0,       1,1,32'h40,32'h12345678, 0,0,        2'b10,2'b00,0,0,0,0, 0,        0,            32'hDEADBEEF, 0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b00,1,1,1,1, 32'h40,   32'h12345678, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             1,32'hCAFE0001, 2'b00,2'b00,1,1,1,1, 32'h40,   32'h12345678, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b10,0,1,1,0, 0,        0,            32'hDEADBEEF, 32'hCAFE0001));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b00,0,0,1,0, 0,        0,            32'hDEADBEEF, 32'hCAFE0001));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             1,32'h00000BAD, 2'b00,2'b00,0,0,1,0, 0,        0,            32'hDEADBEEF, 32'hCAFE0001));
      vecs.push_back(mk(0,0,0,0,       0,0,0,0,             0,0,            2'b00,2'b00,0,0,1,0, 0,        0,            32'hDEADBEEF, 32'hCAFE0001));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v0, vecs[i].t0, vecs[i].a0, vecs[i].v1, vecs[i].t1, vecs[i].a1,
               vecs[i].cd, vecs[i].crd);
         bus.req0_wdata = vecs[i].w0;
         bus.req1_wdata = vecs[i].w1;
         #1;
         chk($sformatf("v%0d_rdy", i),  rdy(), vecs[i].e_rdy);
         chk($sformatf("v%0d_done", i), dn(), vecs[i].e_done);
         chk($sformatf("v%0d_cvld", i), bus.c_req_valid, vecs[i].e_cvld);
         chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].e_busy);
         chk($sformatf("v%0d_gid", i),  bus.grant_id, vecs[i].e_gid);
         chk($sformatf("v%0d_rd0", i),  bus.req0_rdata, vecs[i].e_rd0);
         chk($sformatf("v%0d_rd1", i),  bus.req1_rdata, vecs[i].e_rd1);
         if (vecs[i].e_cvld) begin
            chk($sformatf("v%0d_caddr", i), bus.c_addr, vecs[i].e_caddr);
            chk($sformatf("v%0d_cwdat", i), bus.c_wdata, vecs[i].e_cwdata);
            chk($sformatf("v%0d_ctype", i), bus.c_req_type, vecs[i].e_ctype);
         end
      end

      // ---- long miss: 20 wait cycles, port 1 waiting throughout ----
      @(negedge clk);
      drive(1, 0, 32'h200, 0, 0, 0, 0, 0);
      #1;
      chk("lm_accept", rdy(), 2'b01);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(0, 0, 0, 1, 0, 32'h300, 0, 0);
         #1;
         chk($sformatf("lm_cvld%0d", k),  bus.c_req_valid, 1);
         chk($sformatf("lm_caddr%0d", k), bus.c_addr, 32'h200);
         chk($sformatf("lm_rdy%0d", k),   rdy(), 2'b00);
      end
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 32'h300, 1, 32'h55AA55AA);
      #1;
      chk("lm_cvld_done", bus.c_req_valid, 1);
      chk("lm_rdy_done",  rdy(), 2'b00);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 32'h300, 0, 0);
      #1;
      chk("lm_resp_done", dn(), 2'b01);
      chk("lm_resp_rdy",  rdy(), 2'b00);
      chk("lm_resp_cvld", bus.c_req_valid, 0);
      chk("lm_resp_rd0",  bus.req0_rdata, 32'h55AA55AA);
      @(negedge clk);
      #1;
      chk("lm_p1_accept", rdy(), 2'b10);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 1, 32'h00000077);
      #1;
      chk("lm_p1_caddr", bus.c_addr, 32'h300);
      chk("lm_p1_gid",   bus.grant_id, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("lm_p1_done", dn(), 2'b10);
      chk("lm_p1_rd1",  bus.req1_rdata, 32'h00000077);

      // ---- tie x3 with both requesters valid continuously ----
`ifdef ARB_ROUND_ROBIN_EN
      exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`else
      exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1, 0, 32'hA00, 1, 0, 32'hB00, 1, 32'h1000 + k);
         #1;
         chk($sformatf("tie%0d_rdy", k),   rdy(), exp_g[k] ? 2'b10 : 2'b01);
         chk($sformatf("tie%0d_idle", k),  bus.c_req_valid, 0);
         @(negedge clk);
         #1;
         chk($sformatf("tie%0d_cvld", k),  bus.c_req_valid, 1);
         chk($sformatf("tie%0d_gid", k),   bus.grant_id, exp_g[k]);
         chk($sformatf("tie%0d_caddr", k), bus.c_addr, exp_g[k] ? 32'hB00 : 32'hA00);
         chk($sformatf("tie%0d_rdyw", k),  rdy(), 2'b00);
         @(negedge clk);
         #1;
         chk($sformatf("tie%0d_done", k),  dn(), exp_g[k] ? 2'b10 : 2'b01);
         chk($sformatf("tie%0d_rcvld", k), bus.c_req_valid, 0);
         chk($sformatf("tie%0d_rrdy", k),  rdy(), 2'b00);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("tie_end_busy", bus.busy, 0);

      // ---- reset asserted mid-ISSUE ----
      @(negedge clk);
      drive(1, 0, 32'h400, 0, 0, 0, 0, 0);
      #1;
      chk("rm_accept", rdy(), 2'b01);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rm_cvld_pre", bus.c_req_valid, 1);
      rst = 1'b1;
      #1;
      chk("rm_cvld_async", bus.c_req_valid, 0);
      chk("rm_busy_async", bus.busy, 0);
      chk("rm_gid_async",  bus.grant_id, 0);
      chk("rm_rd0_async",  bus.req0_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFF0000);
         #1;
         chk($sformatf("rm_done%0d", k), dn(), 2'b00);
         chk($sformatf("rm_busy%0d", k), bus.busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter DATA_W, default 32, read/write data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  port N (N=0,1) request pending; held with payload until accepted.
REQ-006 reqN_type  input  1  port N access type: 0 read, 1 write.
REQ-007 reqN_addr  input  ADDR_W  port N address.
REQ-008 reqN_wdata  input  DATA_W  port N write data.
REQ-009 reqN_ready  output  1  combinational; port N request accepted this cycle.
REQ-010 reqN_done  output  1  one-cycle pulse; port N access completed.
REQ-011 reqN_rdata  output  DATA_W  port N read data; valid when reqN_done=1.
REQ-012 c_req_valid  output  1  registered request to cache controller.
REQ-013 c_req_type, c_addr, c_wdata  output  1/ADDR_W/DATA_W  latched payload to cache controller.
REQ-014 c_done_cache  input  1  cache controller completion.
REQ-015 c_rdata  input  DATA_W  cache controller read data; sampled with c_done_cache.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 grant_id  output  1  port owning the current transaction.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-019 IDLE: if any reqN_valid, select winner, assert its reqN_ready combinationally, latch type/addr/wdata and grant_id, go ISSUE at next edge.
REQ-020 IDLE with no valid request: remain IDLE, all ready low.
REQ-021 ISSUE: c_req_valid=1, payload held stable; on c_done_cache=1 capture c_rdata into reqN_rdata of grant_id, go RESP.
REQ-022 c_req_valid SHALL deassert on the same edge that samples c_done_cache=1.
REQ-023 RESP: reqN_done=1 for grant_id only, exactly one cycle; c_req_valid=0; then IDLE.
REQ-024 Minimum accept-to-done latency 3 cycles (accept edge, >=1 ISSUE cycle, RESP); at least one idle cycle of c_req_valid between consecutive transactions.
REQ-025 At most one ready per cycle; never both reqN_done high.
REQ-026 c_done_cache in IDLE or RESP SHALL be ignored.
REQ-027 New requests (either port, including granted one) arriving in ISSUE/RESP SHALL wait until IDLE.
REQ-028 Requester dropping reqN_valid before ready: no transaction, no state change.
REQ-029 reqN_rdata SHALL hold its value until the next done for that port; write transactions also update it with c_rdata.
REQ-030 Simultaneous valid on both ports: resolved per Configuration.

Reset
REQ-031 rst=1 asynchronously forces IDLE; c_req_valid, busy, grant_id, reqN_done, c_req_type, c_addr, c_wdata, reqN_rdata = 0; last-grant register = 1 (port 0 wins first tie).
REQ-032 rst mid-transaction abandons it; no reqN_done issued for it.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: tie goes to port not granted last; last-grant updates on each accept.
REQ-034 ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties; last-grant register absent.

Verification
REQ-035 Single read: req0_valid=1,type=0,addr=0x100 in IDLE -> req0_ready same cycle, c_req_valid=1 next cycle with c_addr=0x100; c_done_cache=1,c_rdata=0xDEADBEEF -> next cycle req0_done=1, req0_rdata=0xDEADBEEF.
REQ-036 Single write (write-hit style): req1 type=1, addr=0x40, wdata=0x12345678, c_done_cache one cycle after issue -> c_wdata=0x12345678, req1_done 1 cycle, grant_id=1.
REQ-037 Tie x3 back-to-back: both valid continuously -> RR: grants 0,1,0; fixed: 0,0,0; one idle c_req_valid cycle between each.
REQ-038 Stray done: c_done_cache=1 in IDLE -> no reqN_done, state stays IDLE.
REQ-039 Reset mid-ISSUE: rst=1 while c_req_valid=1 -> c_req_valid=0 immediately (async), busy=0, no req done pulse after release.
REQ-040 Long miss: c_done_cache delayed 20 cycles -> c_req_valid and payload stable all 20 cycles, req1_valid during wait not accepted until after RESP.
